// File: rtl/osd_pkg.sv
// Shared constants, FSM state type and font-address helper for the OSD character path.
package osd_pkg;

    localparam int unsigned DefCharPicWidth  = 9;
    localparam int unsigned DefCharPicHeight = 18;
    localparam int unsigned DefCharCodeW     = 7;
    localparam int unsigned DefRomAddrW      = 12;
    localparam int unsigned DefScreenWidth   = 1920;
    localparam int unsigned DefScreenHeight  = 1080;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StWait,
        StSend
    } state_e;

    // Glyphs are stored back to back, `height` rows per code.
    function automatic int unsigned glyph_addr(input int unsigned code,
                                               input int unsigned row,
                                               input int unsigned height);
        return code * height + row;
    endfunction

endpackage

// File: rtl/osd_char_row_scheduler.sv
// Fetches one glyph row at a time from the font ROM and hands each row, with its screen
// coordinates, to the pixel shifter; clips rows below the screen and drops off-screen glyphs.
module osd_char_row_scheduler
    import osd_pkg::*;
#(
    parameter int unsigned CHAR_PIC_WIDTH  = DefCharPicWidth,
    parameter int unsigned CHAR_PIC_HEIGHT = DefCharPicHeight,
    parameter int unsigned CHAR_CODE_W     = DefCharCodeW,
    parameter int unsigned ROM_ADDR_W      = DefRomAddrW,
    parameter int unsigned SCREEN_WIDTH    = DefScreenWidth,
    parameter int unsigned SCREEN_HEIGHT   = DefScreenHeight
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHAR_CODE_W-1:0]    s_char_code,
    input  logic [10:0]               s_char_posX,
    input  logic [10:0]               s_char_posY,
    input  logic                      s_char_valid,
    output logic                      s_char_ready,
    output logic                      rom_en,
    output logic [ROM_ADDR_W-1:0]     rom_addr,
    input  logic [CHAR_PIC_WIDTH-1:0] rom_data,
    output logic [CHAR_PIC_WIDTH-1:0] m_row_data,
    output logic [10:0]               m_row_posX,
    output logic [10:0]               m_row_posY,
    output logic                      m_row_valid,
    input  logic                      m_row_ready,
    output logic                      busy,
    output logic                      char_done
);

    localparam int unsigned RowW = (CHAR_PIC_HEIGHT > 1) ? $clog2(CHAR_PIC_HEIGHT) : 1;

    state_e                    state_q;
    logic [CHAR_CODE_W-1:0]    code_q;
    logic [10:0]               posx_q;
    logic [10:0]               posy_q;
    logic [RowW-1:0]           row_q;
    logic                      s_char_ready_q;
    logic                      rom_en_q;
    logic [ROM_ADDR_W-1:0]     rom_addr_q;
    logic [CHAR_PIC_WIDTH-1:0] m_row_data_q;
    logic [10:0]               m_row_posx_q;
    logic [10:0]               m_row_posy_q;
    logic                      m_row_valid_q;
    logic                      busy_q;
    logic                      char_done_q;

    logic [11:0]           row_y;
    logic [11:0]           row_y_next;
    logic                  last_row;
    logic                  off_screen;
    logic [ROM_ADDR_W-1:0] addr_first;
    logic [ROM_ADDR_W-1:0] addr_next;

    // Line arithmetic is one bit wider so the bottom-clip compare cannot wrap.
    always_comb begin
        row_y      = {1'b0, posy_q} + 12'(row_q);
        row_y_next = row_y + 12'd1;
        last_row   = (32'(row_q) == CHAR_PIC_HEIGHT - 1) ||
                     (32'(row_y_next) >= SCREEN_HEIGHT);
        off_screen = (32'(s_char_posX) >= SCREEN_WIDTH) ||
                     (32'(s_char_posY) >= SCREEN_HEIGHT);
        addr_first = ROM_ADDR_W'(glyph_addr(32'(s_char_code), 32'd0, CHAR_PIC_HEIGHT));
        addr_next  = ROM_ADDR_W'(glyph_addr(32'(code_q), 32'(row_q) + 32'd1, CHAR_PIC_HEIGHT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            code_q         <= '0;
            posx_q         <= '0;
            posy_q         <= '0;
            row_q          <= '0;
            s_char_ready_q <= 1'b1;
            rom_en_q       <= 1'b0;
            rom_addr_q     <= '0;
            m_row_data_q   <= '0;
            m_row_posx_q   <= '0;
            m_row_posy_q   <= '0;
            m_row_valid_q  <= 1'b0;
            busy_q         <= 1'b0;
            char_done_q    <= 1'b0;
        end else begin
            char_done_q <= 1'b0;
            rom_en_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (s_char_valid && s_char_ready_q) begin
                        code_q <= s_char_code;
                        posx_q <= s_char_posX;
                        posy_q <= s_char_posY;
                        row_q  <= '0;
                        if (off_screen) begin
                            char_done_q <= 1'b1;
                        end else begin
                            state_q        <= StFetch;
                            rom_en_q       <= 1'b1;
                            rom_addr_q     <= addr_first;
                            s_char_ready_q <= 1'b0;
                            busy_q         <= 1'b1;
                        end
                    end
                end
                StFetch: begin
                    state_q <= StWait;
                end
                StWait: begin
                    m_row_data_q  <= rom_data;
                    m_row_posx_q  <= posx_q;
                    m_row_posy_q  <= row_y[10:0];
                    m_row_valid_q <= 1'b1;
                    state_q       <= StSend;
                end
                StSend: begin
                    if (m_row_ready) begin
                        m_row_valid_q <= 1'b0;
                        if (last_row) begin
                            char_done_q    <= 1'b1;
                            s_char_ready_q <= 1'b1;
                            busy_q         <= 1'b0;
                            state_q        <= StIdle;
                        end else begin
                            row_q      <= row_q + RowW'(1);
                            rom_en_q   <= 1'b1;
                            rom_addr_q <= addr_next;
                            state_q    <= StFetch;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign s_char_ready = s_char_ready_q;
    assign rom_en       = rom_en_q;
    assign rom_addr     = rom_addr_q;
    assign m_row_data   = m_row_data_q;
    assign m_row_posX   = m_row_posx_q;
    assign m_row_posY   = m_row_posy_q;
    assign m_row_valid  = m_row_valid_q;
    assign busy         = busy_q;
    assign char_done    = char_done_q;

endmodule

// File: doc/osd_char_row_scheduler.md
Name: osd_char_row_scheduler

Overview:
- Sequences the OSD per-row pixel shifter.
- Accepts one character request at a time, carrying an ASCII code and the top-left screen position.
- Reads the glyph's CHAR_PIC_HEIGHT rows one by one from a synchronous font ROM.
- Presents each row, with its screen coordinates, to the shifter over a valid/ready handshake.
- Sits between the OSD text source (UDP command parser / string buffer) and the pixel shifter.

Parameters:
- CHAR_PIC_WIDTH, 9: glyph row width in bits; also the shifter input width.
- CHAR_PIC_HEIGHT, 18: rows per glyph.
- CHAR_CODE_W, 7: width of the character code.
- ROM_ADDR_W, 12: font ROM address width. Must satisfy 2^CHAR_CODE_W*CHAR_PIC_HEIGHT <= 2^ROM_ADDR_W.
- SCREEN_WIDTH, 1920: active pixels per line.
- SCREEN_HEIGHT, 1080: active lines.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_char_code  in  CHAR_CODE_W  character code
- s_char_posX  in  11  glyph left column
- s_char_posY  in  11  glyph top line
- s_char_valid  in  1  request valid
- s_char_ready  out  1  request accepted when valid&ready
- rom_en  out  1  font ROM read enable
- rom_addr  out  ROM_ADDR_W  font ROM address
- rom_data  in  CHAR_PIC_WIDTH  ROM data; valid the cycle after rom_en (1-cycle latency)
- m_row_data  out  CHAR_PIC_WIDTH  glyph row, MSB = leftmost pixel
- m_row_posX  out  11  row start column
- m_row_posY  out  11  row line
- m_row_valid  out  1  row valid
- m_row_ready  in  1  shifter ready
- busy  out  1  high in any state other than IDLE
- char_done  out  1  one-cycle pulse when a character finishes or is dropped

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, s_char_ready=1, m_row_valid=0, rom_en=0, char_done=0, busy=0.
  - rom_addr, m_row_*, row counter and latched code/position all reset to 0.
- FSM states: IDLE, FETCH, WAIT, SEND.
- IDLE:
  - s_char_ready=1 (registered). It is 0 in every other state.
  - On valid&ready, latch code, posX, posY; set row=0.
  - If posX>=SCREEN_WIDTH or posY>=SCREEN_HEIGHT: drop the character, pulse char_done next cycle, stay in IDLE. No ROM read and no rows are issued.
  - Otherwise go to FETCH.
- FETCH:
  - rom_en=1 for exactly one cycle.
  - rom_addr = code*CHAR_PIC_HEIGHT + row. Computed at full width, then truncated to ROM_ADDR_W.
  - Next state is WAIT.
- WAIT:
  - Register rom_data into m_row_data.
  - m_row_posX = latched posX; m_row_posY = posY + row (11-bit).
  - Set m_row_valid=1 and go to SEND.
- SEND:
  - Hold m_row_valid and all m_row_* stable until m_row_ready.
  - On valid&ready, m_row_valid falls the next cycle, then:
    - If row==CHAR_PIC_HEIGHT-1 or posY+row+1>=SCREEN_HEIGHT (bottom clip): pulse char_done and go to IDLE.
    - Otherwise row+=1 and go to FETCH.
- Latency: first m_row_valid is asserted 3 cycles after the request handshake. Each subsequent row is asserted 3 cycles after the previous row's handshake.
- Back-to-back characters: a new request can be accepted in the cycle after char_done; s_char_ready rises together with char_done.
- No requirement on m_row_ready timing; a combinational ready from the shifter is permitted. The block never depends on ready to raise valid.
- A row at posY+row == SCREEN_HEIGHT-1 is still sent. Rows at posY+row >= SCREEN_HEIGHT are never sent.
- Horizontal clipping inside a row is left to the shifter; posX near the right edge is forwarded unchanged.
- Reset mid-character: immediate return to IDLE with outputs at reset values. The interrupted row is abandoned and no char_done pulse is produced.
- Only one ROM read is outstanding at any time.

Decomposition:
- Shared package osd_pkg holds:
  - CHAR_PIC_WIDTH, CHAR_PIC_HEIGHT, SCREEN_WIDTH, SCREEN_HEIGHT defaults.
  - The state enum (IDLE/FETCH/WAIT/SEND).
  - A function computing glyph_addr(code,row).
- Single flat module. The address computation is a small function, not a sub-module.
- Top level osd_char_path instantiates this block together with the font ROM and pixels_shifter.

Test Plan:
- Single char: code 0x41 at (100,200), ROM model returns row index as data, ready tied 1.
  - rom_addr sequence 1170..1187.
  - 18 rows with posY 200..217, posX 100.
  - First valid 3 cycles after accept; one char_done.
- Backpressure: same char, m_row_ready toggling randomly.
  - m_row_* stable while valid&!ready.
  - No rows lost or duplicated.
  - s_char_ready stays 0 until char_done.
- Bottom clip: char at posY=1070.
  - Exactly 10 rows sent (1070..1079), then char_done.
  - rom_en pulses exactly 10 times.
- Off-screen drop: posX=1920 or posY=1080.
  - Accepted, char_done the next cycle, no rom_en, no m_row_valid.
- Back-to-back: two chars queued with valid held high.
  - Second accept in the cycle after the first char_done.
  - 36 rows total, in order.
- Reset at row 5 of a character.
  - m_row_valid=0, busy=0, s_char_ready=1 immediately.
  - The next character starts cleanly from row 0.
